bit_serial_adder: RTL and testbench

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/bit_serial_adder_pkg.sv | 11 +
 rtl/full_adder.sv | 16 +
 rtl/bit_serial_adder.sv | 142 ++++++++++++++
 tb/tb_bit_serial_adder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding.
package bit_serial_adder_pkg;

  // Controller states: waiting for operands, shifting bits, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used for the per-bit add in the serial datapath.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  // Plain gate-level full-adder equations.
  always_comb begin
    sum_o  = a_i ^ b_i ^ cin_i;
    cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
  end

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial unsigned adder: one bit per clock, LSB first, with a
// valid/ready handshake on both operand input and result output.
// Optional build macro BIT_SERIAL_ADDER_OVF_EN adds the ovf output
// (two's-complement overflow of the same addition).
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef BIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             last_bit;
  logic             fa_sum;
  logic             fa_cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // The only arithmetic on the datapath: one full adder reused every RUN cycle.
  full_adder u_fa (
    .a_i   (a_sh_q[0]),
    .b_i   (b_sh_q[0]),
    .cin_i (carry_q),
    .sum_o (fa_sum),
    .cout_o(fa_cout)
  );

  // Controller next state and handshake outputs, decoded from the state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last_bit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        last_bit = (cnt_q == CNT_LAST);
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: load on accept, shift one bit per RUN cycle.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    if (accept) begin
      a_sh_d   = a;
      b_sh_d   = b;
      sum_sh_d = '0;
      carry_d  = cin;
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
      carry_d  = fa_cout;
      // Counter holds at its last value so it never wraps for power-of-two widths.
      if (!last_bit) cnt_d = cnt_q + CNT_W'(1);
`ifdef BIT_SERIAL_ADDER_OVF_EN
      // On the MSB, carry_q is the carry into the MSB and fa_cout the carry out.
      if (last_bit) ovf_d = carry_q ^ fa_cout;
`endif
    end
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // After the last bit the carry register holds the final carry out.
  assign sum  = sum_sh_q;
  assign cout = carry_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Testbench for bit_serial_adder: scoreboard of expected results fed by the
// stimulus process, checked by an independent output monitor.
module tb_bit_serial_adder;

  localparam int W = 8;
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int unsigned  acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  bit          rand_bp = 1'b0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer addition, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    exp_t e;
    logic [W:0] full;
    full = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);
    e.acc_cyc = 0;
    return e;
  endfunction

  // Monitor: latency on first valid cycle, stability under backpressure, compare on transfer.
  logic [W-1:0] prev_sum;
  logic         prev_cout;
  bit           have_prev = 1'b0;
  bit           first_seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      have_prev  = 1'b0;
      first_seen = 1'b0;
    end else if (out_valid) begin
      if (have_prev) begin
        check("stable_sum", 64'(sum), 64'(prev_sum));
        check("stable_cout", 64'(cout), 64'(prev_cout));
      end
      if (!first_seen) begin
        first_seen = 1'b1;
        // Accept edge plus W RUN edges: W+1 edges counting the accept edge.
        if (exp_q.size() > 0) check("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(W));
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          $display("result sum=%0d cout=%0d (exp sum=%0d cout=%0d)", sum, cout, e.sum, e.cout);
          check("sum", 64'(sum), 64'(e.sum));
          check("cout", 64'(cout), 64'(e.cout));
`ifdef BIT_SERIAL_ADDER_OVF_EN
          check("ovf", 64'(ovf), 64'(e.ovf));
`endif
        end
        have_prev  = 1'b0;
        first_seen = 1'b0;
      end else begin
        have_prev = 1'b1;
        prev_sum  = sum;
        prev_cout = cout;
      end
    end else begin
      have_prev  = 1'b0;
      first_seen = 1'b0;
    end
  end

  // Random consumer backpressure, applied after the driver's slot in each cycle.
  always @(posedge clk) begin
    #2;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  end

  // All tasks start and end at posedge + 1.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(0), 64'(1));
      return;
    end
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    e = model(ta, tb_, tc);
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    $display("issue a=%0d b=%0d cin=%0d", ta, tb_, tc);
    in_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 64'(n < 200), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_sum"}, 64'(sum), 64'(0));
    check({tag, "_cout"}, 64'(cout), 64'(0));
`ifdef BIT_SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(0));
`endif
  endtask

  initial begin
    int n;
    #1;
    check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases, out_ready held high.
    issue(8'd3, 8'd5, 1'b0);
    wait_drained();
    issue(8'd255, 8'd1, 1'b0);
    issue(8'd127, 8'd1, 1'b0);
    issue(ALL_ONES, ALL_ONES, 1'b1);
    wait_drained();

    // Backpressure: result held for 5 cycles in DONE.
    out_ready = 1'b0;
    issue(8'd100, 8'd57, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid_timeout", 64'(out_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", 64'(in_ready), 64'(1));
    wait_drained();

    // Reset in the middle of RUN, after four bits have been processed.
    issue(8'd200, 8'd100, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'd10, 8'd20, 1'b0);
    wait_drained();

    // Operands offered while busy are ignored.
    issue(8'd3, 8'd5, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 8'd1; b = 8'd1; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    check("busy_in_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    wait_drained();
    repeat (20) @(posedge clk);
    #1;

    // Random operands with random consumer backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? ALL_ONES : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ALL_ONES : W'($urandom);
      issue(ra, rb, 1'($urandom_range(0, 1)));
    end
    @(posedge clk); #1;
    rand_bp = 1'b0;
    out_ready = 1'b1;
    wait_drained();

    repeat (30) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
